// File: rtl/komandara_bram_arb_pkg.sv
// Shared helpers for the komandara BRAM arbiter and its round-robin picker.
package komandara_bram_arb_pkg;

    // Index width for N items; never below 1 so N=1 still gets a real signal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/komandara_rr_arbiter.sv
// N-way round-robin picker: scans from the pointer, emits one-hot grant and binary
// index, and moves the pointer just past the winner when advance is asserted.
module komandara_rr_arbiter
    import komandara_bram_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = clog2_min1(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // One extra bit holds ptr+offset before the modulo fold, so non-power-of-2 N wraps cleanly.
    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W:0]   cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!o_valid && i_req[cand[IDX_W-1:0]]) begin
                o_valid                  = 1'b1;
                o_idx                    = cand[IDX_W-1:0];
                o_gnt[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (i_advance && o_valid) begin
            if (o_idx == IDX_W'(N-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = o_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/komandara_bram_arbiter.sv
// Shares one komandara_bram port between N_REQ masters, one grant per cycle.
// Optional: define KOMANDARA_BRAM_ARB_PRIO0_EN to give requester 0 fixed top priority.
module komandara_bram_arbiter
    import komandara_bram_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [N_REQ-1:0]                 i_req,
    input  logic [N_REQ-1:0]                 i_we,
    input  logic [N_REQ*MEM_ADDR_WIDTH-1:0]  i_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]      i_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]    i_wstrb,
    output logic [N_REQ-1:0]                 o_gnt,
    output logic [N_REQ-1:0]                 o_rvalid,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             m_req,
    output logic                             m_we,
    output logic [MEM_ADDR_WIDTH-1:0]        m_addr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    input  logic                             m_rvalid,
    input  logic [DATA_WIDTH-1:0]            m_rdata
);

    localparam int unsigned IDX_W  = clog2_min1(N_REQ);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [STRB_W-1:0]         wstrb;
    } payload_t;

    payload_t         req_pl [N_REQ];
    payload_t         win_pl;

    logic [N_REQ-1:0] rr_req;
    logic [N_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_valid;
    logic             rr_adv;

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;

    logic             rd_pend_q;
    logic             rd_pend_d;
    logic [IDX_W-1:0] rd_tag_q;
    logic [IDX_W-1:0] rd_tag_d;

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            req_pl[k].we    = i_we[k];
            req_pl[k].addr  = i_addr[k*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            req_pl[k].wdata = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            req_pl[k].wstrb = i_wstrb[k*STRB_W +: STRB_W];
        end
    end

    komandara_rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (rr_req),
        .i_advance (rr_adv),
        .o_gnt     (rr_gnt),
        .o_idx     (rr_idx),
        .o_valid   (rr_valid)
    );

`ifdef KOMANDARA_BRAM_ARB_PRIO0_EN
    // Requester 0 is masked from the picker, so the pointer only rotates among 1..N_REQ-1.
    always_comb begin
        rr_req    = i_req;
        rr_req[0] = 1'b0;
        rr_adv    = ~i_req[0];
        if (i_req[0]) begin
            gnt       = '0;
            gnt[0]    = 1'b1;
            win_idx   = '0;
            win_valid = 1'b1;
        end else begin
            gnt       = rr_gnt;
            win_idx   = rr_idx;
            win_valid = rr_valid;
        end
    end
`else
    always_comb begin
        rr_req    = i_req;
        rr_adv    = 1'b1;
        gnt       = rr_gnt;
        win_idx   = rr_idx;
        win_valid = rr_valid;
    end
`endif

    always_comb begin
        win_pl = '0;
        if (win_valid) begin
            win_pl = req_pl[win_idx];
        end
    end

    always_comb begin
        o_gnt   = gnt;
        m_req   = win_valid;
        m_we    = win_pl.we;
        m_addr  = win_pl.addr;
        m_wdata = win_pl.wdata;
        m_wstrb = win_pl.wstrb;
    end

    // Tag is only rewritten by a new read grant, after this cycle's response used it.
    always_comb begin
        rd_pend_d = win_valid & ~win_pl.we;
        rd_tag_d  = rd_tag_q;
        if (rd_pend_d) begin
            rd_tag_d = win_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (m_rvalid && rd_pend_q) begin
            o_rvalid[rd_tag_q] = 1'b1;
        end
    end

    assign o_rdata = m_rdata;

endmodule

// File: tb/tb_komandara_bram_arbiter.sv
// Randomised bench for komandara_bram_arbiter against a queue-free spec-level model.
module tb_komandara_bram_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    i_req, i_we, o_gnt, o_rvalid;
    logic [N*AW-1:0] i_addr;
    logic [N*DW-1:0] i_wdata;
    logic [N*SW-1:0] i_wstrb;
    logic [DW-1:0]   o_rdata;
    logic            m_req, m_we, m_rvalid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [SW-1:0]   m_wstrb;

    komandara_bram_arbiter #(
        .N_REQ          (N),
        .MEM_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_req (i_req), .i_we (i_we), .i_addr (i_addr), .i_wdata (i_wdata), .i_wstrb (i_wstrb),
        .o_gnt (o_gnt), .o_rvalid (o_rvalid), .o_rdata (o_rdata),
        .m_req (m_req), .m_we (m_we), .m_addr (m_addr), .m_wdata (m_wdata), .m_wstrb (m_wstrb),
        .m_rvalid (m_rvalid), .m_rdata (m_rdata)
    );

    // Three-requester instance for the non-power-of-2 rotation check.
    logic [2:0]    r3_req, r3_gnt, r3_rvalid;
    logic [3*AW-1:0] r3_addr;
    logic [3*DW-1:0] r3_wdata;
    logic [3*SW-1:0] r3_wstrb;
    logic [DW-1:0] r3_rdata, r3_m_wdata;
    logic          r3_m_req, r3_m_we;
    logic [AW-1:0] r3_m_addr;
    logic [SW-1:0] r3_m_wstrb;

    komandara_bram_arbiter #(
        .N_REQ          (3),
        .MEM_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW)
    ) dut3 (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_req (r3_req), .i_we (3'b000), .i_addr (r3_addr), .i_wdata (r3_wdata), .i_wstrb (r3_wstrb),
        .o_gnt (r3_gnt), .o_rvalid (r3_rvalid), .o_rdata (r3_rdata),
        .m_req (r3_m_req), .m_we (r3_m_we), .m_addr (r3_m_addr), .m_wdata (r3_m_wdata), .m_wstrb (r3_m_wstrb),
        .m_rvalid (1'b0), .m_rdata ('0)
    );

    // Environment BRAM: 1-cycle read latency, byte strobes, optional stray responses.
    logic [DW-1:0] bram [256];
    logic          stray_en;
    always @(posedge clk) begin
        if (m_req && m_we) begin
            for (int b = 0; b < SW; b++)
                if (m_wstrb[b]) bram[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        if (m_req && !m_we) begin
            m_rvalid <= 1'b1;
            m_rdata  <= bram[m_addr[7:0]];
        end else begin
            m_rvalid <= stray_en && ($urandom_range(0, 2) == 0);
            m_rdata  <= $urandom;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    int            mdl_ptr;
    bit            exp_pend;
    int            exp_tag;
    logic [DW-1:0] exp_data;
    int            last_w;
    logic [DW-1:0] seen_rdata;
    logic [N-1:0]  seen_rvalid;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] req, input int ptr);
`ifdef KOMANDARA_BRAM_ARB_PRIO0_EN
        if (req[0]) return 0;
`endif
        for (int s = 0; s < N; s++) begin
            int k;
            k = (ptr + s) % N;
`ifdef KOMANDARA_BRAM_ARB_PRIO0_EN
            if (k == 0) continue;
`endif
            if (req[k]) return k;
        end
        return -1;
    endfunction

    // Called just after a rising edge with inputs set; checks one cycle, advances the model.
    task automatic cycle_check();
        int           w;
        int           a;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        @(negedge clk);
        w  = model_winner(i_req, mdl_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk_eq("gnt", o_gnt, eg);
        chk_eq("m_req", m_req, (w >= 0));
        if (w >= 0) begin
            chk_eq("m_we", m_we, i_we[w]);
            chk_eq("m_addr", m_addr, i_addr[w*AW +: AW]);
            if (i_we[w]) begin
                chk_eq("m_wdata", m_wdata, i_wdata[w*DW +: DW]);
                chk_eq("m_wstrb", m_wstrb, i_wstrb[w*SW +: SW]);
            end
        end else begin
            chk_eq("m_we_idle", m_we, 1'b0);
            chk_eq("m_addr_idle", m_addr, '0);
        end
        erv = '0;
        if (exp_pend) erv[exp_tag] = 1'b1;
        chk_eq("rvalid", o_rvalid, erv);
        if (exp_pend) chk_eq("rdata", o_rdata, exp_data);
        seen_rdata  = o_rdata;
        seen_rvalid = o_rvalid;

        exp_pend = 1'b0;
        if (w >= 0) begin
            a = int'(i_addr[w*AW +: 8]);
            if (i_we[w]) begin
                for (int b = 0; b < SW; b++)
                    if (i_wstrb[w*SW + b]) ref_mem[a][8*b +: 8] = i_wdata[w*DW + 8*b +: 8];
            end else begin
                exp_pend = 1'b1;
                exp_tag  = w;
                exp_data = ref_mem[a];
            end
`ifdef KOMANDARA_BRAM_ARB_PRIO0_EN
            if (w != 0) mdl_ptr = (w + 1) % N;
`else
            mdl_ptr = (w + 1) % N;
`endif
        end
        last_w = w;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic we, input int addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st);
        i_req[k]             = 1'b1;
        i_we[k]              = we;
        i_addr[k*AW +: AW]   = AW'(addr);
        i_wdata[k*DW +: DW]  = wd;
        i_wstrb[k*SW +: SW]  = st;
    endtask

    task automatic random_update();
        for (int k = 0; k < N; k++) begin
            if (!i_req[k] || last_w == k) begin
                set_req(k, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 47)), $urandom, SW'($urandom));
                i_req[k] = ($urandom_range(0, 3) != 0);
            end else if ($urandom_range(0, 15) == 0) begin
                i_req[k] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        int            exp3 [6];
        rst_n    = 1'b0;
        stray_en = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_wstrb = '0;
        r3_req = '0; r3_addr = '0; r3_wdata = '0; r3_wstrb = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            bram[i] = v;
            ref_mem[i] = v;
        end
        bram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        bram[8'h30] = 32'h11223344; ref_mem[8'h30] = 32'h11223344;
        mdl_ptr = 0; exp_pend = 1'b0; exp_tag = 0; last_w = -1;

        repeat (3) @(negedge clk);
        chk_eq("rst_gnt", o_gnt, '0);
        chk_eq("rst_m_req", m_req, 1'b0);
        chk_eq("rst_m_we", m_we, 1'b0);
        chk_eq("rst_rvalid", o_rvalid, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        cycle_check();                                  // idle

        set_req(0, 1'b0, 'h10, '0, '0);                 // single reader
        cycle_check();
        i_req = '0;
        cycle_check();
        chk_eq("read_deadbeef", seen_rdata, 32'hDEADBEEF);
        chk_eq("read_rvalid", seen_rvalid, 2'b01);

        set_req(1, 1'b1, 'h20, 32'hCAFEF00D, 4'hF);     // write then read
        cycle_check();
        i_req = '0;
        set_req(0, 1'b0, 'h20, '0, '0);
        cycle_check();
        i_req = '0;
        cycle_check();
        chk_eq("raw_cafef00d", seen_rdata, 32'hCAFEF00D);
        chk_eq("raw_rvalid", seen_rvalid, 2'b01);

        set_req(0, 1'b1, 'h30, 32'h000000AA, 4'b0001);  // partial strobe
        cycle_check();
        set_req(0, 1'b0, 'h30, '0, '0);
        cycle_check();
        i_req = '0;
        cycle_check();
        chk_eq("strobe_merge", seen_rdata, 32'h112233AA);

        set_req(0, 1'b0, 1, '0, '0);                    // both reading back-to-back
        set_req(1, 1'b0, 2, '0, '0);
        for (int c = 0; c < 8; c++) begin
            cycle_check();
            if (last_w >= 0) set_req(last_w, 1'b0, int'($urandom_range(0, 63)), '0, '0);
        end

        stray_en = 1'b1;                                // randomised traffic
        i_req = '0;
        for (int c = 0; c < 400; c++) begin
            random_update();
            cycle_check();
        end
        stray_en = 1'b0;

        i_req = '0;                                     // reset during an outstanding read
        cycle_check();
        set_req(1, 1'b0, 'h10, '0, '0);
        cycle_check();
        i_req = '0;
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_rvalid", o_rvalid, '0);
        mdl_ptr = 0; exp_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle_check();

        // Three requesters all reading from a freshly reset pointer.
`ifdef KOMANDARA_BRAM_ARB_PRIO0_EN
        exp3 = '{0, 0, 0, 0, 0, 0};
`else
        exp3 = '{0, 1, 2, 0, 1, 2};
`endif
        r3_req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_eq($sformatf("n3_gnt%0d", c), r3_gnt, 3'b001 << exp3[c]);
        end
        r3_req = '0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
